// File: rtl/man_norm_round.sv
// Normalise and round a floating-point mantissa-ALU result into packed sign/exponent/fraction fields.
// Sequential: one left shift per NORM cycle, then a single round-to-nearest-even step.
module man_norm_round #(
  parameter int SIZE_MAN = 28,
  parameter int SIZE_EXP = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sign,
  input  logic [SIZE_EXP-1:0] i_exp,
  input  logic [SIZE_MAN-1:0] i_man_alu,
  input  logic                i_overflow,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_sign,
  output logic [SIZE_EXP-1:0] o_exp,
  output logic [22:0]         o_man,
  output logic                o_zero,
  output logic                o_underflow,
  output logic                o_exp_ovf,
  output logic [1:0]          o_state
);

  // Handshake: an input transfers on a rising edge where i_valid && o_ready;
  // a result transfers on a rising edge where o_valid && i_ready. o_valid holds
  // with stable data until accepted, and the block is busy in between.

  localparam int VW = SIZE_MAN + 1;   // value width including the carry-out bit
  localparam int HB = SIZE_MAN - 2;   // hidden-bit position
  localparam int FW = HB - 3;         // fraction width
  localparam int EW = SIZE_EXP + 2;   // internal exponent width

  localparam logic [EW-1:0] E_ONE = EW'(1);
  localparam logic [EW-1:0] E_TWO = EW'(2);
  localparam logic [EW-1:0] E_MAX = {2'b00, {SIZE_EXP{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [VW-1:0] v_q;
  logic [EW-1:0] e_q;
  logic          sign_q;
  logic          zero_q;
  logic          denorm_q;

  // Capture-time pre-normalisation of carry/headroom bits
  logic [VW-1:0] v_in;
  logic [VW-1:0] v_cap;
  logic [EW-1:0] e_cap;

  always_comb begin
    v_in  = {i_overflow, i_man_alu};
    v_cap = v_in;
    e_cap = {2'b00, i_exp};
    if (v_in[VW-1]) begin
      v_cap    = {2'b00, v_in[VW-1:2]};
      v_cap[0] = v_in[2] | v_in[1] | v_in[0];
      e_cap    = {2'b00, i_exp} + E_TWO;
    end else if (v_in[VW-2]) begin
      v_cap    = {1'b0, v_in[VW-1:1]};
      v_cap[0] = v_in[1] | v_in[0];
      e_cap    = {2'b00, i_exp} + E_ONE;
    end
  end

  // Normalisation decisions
  logic v_is_zero;
  logic hidden_set;
  logic e_low;
  logic norm_done;

  always_comb begin
    v_is_zero  = (v_q == '0);
    hidden_set = v_q[HB];
    e_low      = (e_q <= E_ONE);
    norm_done  = v_is_zero | hidden_set | e_low;
  end

  // Round to nearest even on G/R/S below the fraction LSB
  logic [FW-1:0] frac;
  logic          rnd_inc;
  logic [FW:0]   frac_sum;
  logic          rnd_carry;
  logic [FW-1:0] frac_r;
  logic [EW-1:0] e_r;
  logic          den_r;
  logic          e_ovf;

  always_comb begin
    frac      = v_q[HB-1:3];
    rnd_inc   = v_q[2] & (v_q[1] | v_q[0] | v_q[3]);
    frac_sum  = {1'b0, frac} + {{FW{1'b0}}, rnd_inc};
    rnd_carry = frac_sum[FW];
    frac_r    = rnd_carry ? '0 : frac_sum[FW-1:0];
    // A carry out of a denormal fraction promotes it to the smallest normal.
    if (rnd_carry) e_r = denorm_q ? E_ONE : e_q + E_ONE;
    else           e_r = e_q;
    den_r = denorm_q & ~rnd_carry;
    e_ovf = (e_r >= E_MAX);
  end

  // Packed result selection; zero wins over every other condition
  logic [SIZE_EXP-1:0] res_exp;
  logic [FW-1:0]       res_man;
  logic                res_uf;
  logic                res_ovf;

  always_comb begin
    res_exp = e_r[SIZE_EXP-1:0];
    res_man = frac_r;
    res_uf  = 1'b0;
    res_ovf = 1'b0;
    if (zero_q) begin
      res_exp = '0;
      res_man = '0;
    end else if (e_ovf) begin
      res_exp = '1;
      res_man = '0;
      res_ovf = 1'b1;
    end else if (den_r) begin
      res_exp = '0;
      res_uf  = 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = NORM;
      NORM:    if (norm_done) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
    o_state = state;
  end

  // Datapath and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_q         <= '0;
      e_q         <= '0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      denorm_q    <= 1'b0;
      o_sign      <= 1'b0;
      o_exp       <= '0;
      o_man       <= '0;
      o_zero      <= 1'b0;
      o_underflow <= 1'b0;
      o_exp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            v_q      <= v_cap;
            e_q      <= e_cap;
            sign_q   <= i_sign;
            zero_q   <= 1'b0;
            denorm_q <= 1'b0;
          end
        end
        NORM: begin
          if (v_is_zero) begin
            zero_q <= 1'b1;
          end else if (!hidden_set) begin
            if (e_low) begin
              denorm_q <= 1'b1;
            end else begin
              v_q <= {v_q[VW-2:0], 1'b0};
              e_q <= e_q - E_ONE;
            end
          end
        end
        ROUND: begin
          o_sign      <= sign_q;
          o_exp       <= res_exp;
          o_man       <= res_man;
          o_zero      <= zero_q;
          o_underflow <= res_uf;
          o_exp_ovf   <= res_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_man_norm_round.sv
// Bench for man_norm_round: directed corner cases plus random operands, checked
// against a value-level normalise/round model with a per-cycle compare process.
module tb_man_norm_round;

  localparam int W = 41;  // {latency[5:0], sign, exp[7:0], man[22:0], zero, underflow, exp_ovf}

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_sign = 1'b0;
  logic [7:0]  i_exp = '0;
  logic [27:0] i_man_alu = '0;
  logic        i_overflow = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic        o_sign;
  logic [7:0]  o_exp;
  logic [22:0] o_man;
  logic        o_zero;
  logic        o_underflow;
  logic        o_exp_ovf;
  logic [1:0]  o_state;

  man_norm_round #(.SIZE_MAN(28), .SIZE_EXP(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_man_alu(i_man_alu), .i_overflow(i_overflow),
    .o_valid(o_valid), .i_ready(i_ready), .o_sign(o_sign), .o_exp(o_exp),
    .o_man(o_man), .o_zero(o_zero), .o_underflow(o_underflow),
    .o_exp_ovf(o_exp_ovf), .o_state(o_state)
  );

  // Clock / cycle counter
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int hold_q[$];
  int acc_q[$];
  int n_checks = 0;
  int n_pass = 0;
  bit seen = 0;
  bit hs_pending = 0;
  int hold_cnt = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Reference model: value arithmetic on the 29-bit ALU result
  function automatic logic [W-1:0] model(input logic s, input logic [7:0] e, input logic [27:0] m, input logic ov);
    longint v, mant, rem;
    int ex, p, lz, maxk, k;
    bit zero, den, uf, ovf;
    logic [7:0] oe;
    logic [22:0] om;
    v = longint'({ov, m});
    ex = int'(e);
    zero = 0; den = 0; uf = 0; ovf = 0; k = 0;
    if (v >= 64'h1000_0000) begin
      v = (v >> 2) | longint'((v & 3) != 0);
      ex += 2;
    end else if (v >= 64'h0800_0000) begin
      v = (v >> 1) | (v & 1);
      ex += 1;
    end
    if (v == 0) begin
      zero = 1;
    end else begin
      p = 0;
      for (int i = 0; i <= 26; i++) if (((v >> i) & 1) != 0) p = i;
      lz = 26 - p;
      maxk = (ex > 1) ? ex - 1 : 0;
      k = (lz < maxk) ? lz : maxk;
      v = v << k;
      ex -= k;
      den = (k < lz);
    end
    mant = v >> 3;
    rem = v & 7;
    if (rem > 4 || (rem == 4 && (mant & 1) != 0)) mant++;
    if (den && mant >= 64'h80_0000) begin
      den = 0;
      ex = 1;
    end else if (!den && mant >= 64'h100_0000) begin
      mant = mant >> 1;
      ex++;
    end
    om = mant[22:0];
    oe = ex[7:0];
    if (zero) begin
      oe = '0; om = '0;
    end else if (ex >= 255) begin
      oe = 8'hFF; om = '0; ovf = 1;
    end else if (den) begin
      oe = '0; uf = 1;
    end
    return {6'(3 + k), s, oe, om, zero, uf, ovf};
  endfunction

  task automatic flush();
    exp_q.delete();
    hold_q.delete();
    acc_q.delete();
    seen = 0;
    hold_cnt = 0;
    hs_pending = 0;
  endtask

  // Compare process: every DONE cycle is checked, which also pins stability while stalled
  always @(negedge i_clk) begin
    logic [34:0] got;
    int lat;
    if (i_rst) begin
      i_ready = 1'b0;
      hs_pending = 0;
    end else begin
      if (hs_pending) begin
        void'(exp_q.pop_front());
        void'(hold_q.pop_front());
        void'(acc_q.pop_front());
        seen = 0;
        hold_cnt = 0;
        hs_pending = 0;
        i_ready = 1'b0;
      end
      if (o_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          check(0, "spurious_valid", 64'(o_valid), 64'(0));
        end else begin
          got = {o_sign, o_exp, o_man, o_zero, o_underflow, o_exp_ovf};
          check(got == exp_q[0][34:0], "result", 64'(got), 64'(exp_q[0][34:0]));
          check(o_ready == 1'b0, "ready_in_done", 64'(o_ready), 64'(0));
          if (!seen) begin
            lat = cyc - acc_q[0] + 1;
            check(lat == int'(exp_q[0][40:35]), "latency", 64'(lat), 64'(exp_q[0][40:35]));
            seen = 1;
          end
          if (hold_cnt >= hold_q[0]) begin
            i_ready = 1'b1;
            hs_pending = 1;
          end else begin
            hold_cnt++;
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    i_rst = 1'b1;
    i_valid = 1'b0;
    flush();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m, input logic ov, input int hold);
    int t;
    t = 0;
    while (!o_ready && t < 100) begin
      @(posedge i_clk);
      #1;
      t++;
    end
    check(o_ready == 1'b1, "ready_before_send", 64'(o_ready), 64'(1));
    exp_q.push_back(model(s, e, m, ov));
    hold_q.push_back(hold);
    i_valid = 1'b1; i_sign = s; i_exp = e; i_man_alu = m; i_overflow = ov;
    @(posedge i_clk);
    #1;
    acc_q.push_back(cyc);
    i_valid = 1'b0;
    i_sign = 1'($urandom_range(0, 1));
    i_exp = 8'($urandom);
    i_man_alu = 28'($urandom);
    i_overflow = 1'($urandom_range(0, 1));
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge i_clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      check(0, "done_timeout", 64'(exp_q.size()), 64'(0));
      do_reset();
    end
  endtask

  task automatic pin(input string name, input logic [7:0] e, input logic [27:0] m, input logic [W-1:0] req);
    logic [W-1:0] r;
    r = model(1'b0, e, m, 1'b0);
    check(r == req, name, 64'(r), 64'(req));
  endtask

  initial begin
    logic [27:0] m;
    logic [7:0] e;
    int hold;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check({o_valid, o_sign, o_exp, o_man, o_zero, o_underflow, o_exp_ovf} == '0,
          "reset_outputs", 64'({o_valid, o_sign, o_exp, o_man, o_zero, o_underflow, o_exp_ovf}), 64'(0));
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check(o_ready == 1'b1, "ready_after_reset", 64'(o_ready), 64'(1));

    // Hand-computed expectations pinning the model
    pin("pin_headroom",   8'd127, 28'h8000000, {6'd3, 1'b0, 8'd128, 23'h0, 3'b000});
    pin("pin_two_shifts", 8'd130, 28'h1000000, {6'd5, 1'b0, 8'd128, 23'h0, 3'b000});
    pin("pin_tie_odd",    8'd100, 28'h400000C, {6'd3, 1'b0, 8'd100, 23'h2, 3'b000});
    pin("pin_zero",       8'd90,  28'h0000000, {6'd3, 1'b0, 8'd0,   23'h0, 3'b100});
    pin("pin_exp_ovf",    8'd254, 28'h8000000, {6'd3, 1'b0, 8'hFF,  23'h0, 3'b001});
    pin("pin_denormal",   8'd1,   28'h0000010, {6'd3, 1'b0, 8'd0,   23'h2, 3'b010});
    pin("pin_round_carry", 8'd100, 28'h7FFFFFC, {6'd3, 1'b0, 8'd101, 23'h0, 3'b000});
    pin("pin_den_carry",  8'd1,   28'h3FFFFFC, {6'd3, 1'b0, 8'd1,   23'h0, 3'b000});

    // Directed cases through the DUT; the first stalls 5 cycles in DONE
    send(1'b0, 8'd127, 28'h8000000, 1'b0, 5);
    send(1'b1, 8'd130, 28'h1000000, 1'b0, 0);
    send(1'b0, 8'd100, 28'h400000C, 1'b0, 1);
    send(1'b1, 8'd90,  28'h0000000, 1'b0, 0);
    send(1'b0, 8'd254, 28'h8000000, 1'b0, 2);
    send(1'b0, 8'd1,   28'h0000010, 1'b0, 0);
    send(1'b0, 8'd100, 28'h7FFFFFC, 1'b0, 0);
    send(1'b1, 8'd1,   28'h3FFFFFC, 1'b0, 0);
    send(1'b0, 8'd200, 28'h0000008, 1'b0, 0);
    send(1'b1, 8'd255, 28'hFFFFFFF, 1'b1, 0);
    send(1'b0, 8'd10,  28'h0000001, 1'b0, 0);

    // Reset pulsed while normalising a long shift chain
    exp_q.push_back(model(1'b0, 8'd100, 28'h0000008, 1'b0));
    hold_q.push_back(0);
    i_valid = 1'b1; i_sign = 1'b0; i_exp = 8'd100; i_man_alu = 28'h0000008; i_overflow = 1'b0;
    @(posedge i_clk);
    #1;
    acc_q.push_back(cyc);
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check({o_ready, o_valid} == 2'b00, "busy_flags", 64'({o_ready, o_valid}), 64'(0));
    i_rst = 1'b1;
    flush();
    @(posedge i_clk);
    #1;
    check({o_valid, o_sign, o_exp, o_man, o_zero, o_underflow, o_exp_ovf} == '0,
          "reset_mid_norm", 64'({o_valid, o_sign, o_exp, o_man, o_zero, o_underflow, o_exp_ovf}), 64'(0));
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check({o_ready, o_valid} == 2'b10, "ready_after_mid_reset", 64'({o_ready, o_valid}), 64'(2));
    repeat (30) @(posedge i_clk);
    #1;
    check(o_valid == 1'b0, "no_stale_result", 64'(o_valid), 64'(0));

    // Random operands with mixed leading-zero counts and exponent ranges
    for (int n = 0; n < 200; n++) begin
      m = 28'($urandom) >> $urandom_range(0, 28);
      case ($urandom_range(0, 3))
        0: e = 8'($urandom_range(0, 255));
        1: e = 8'($urandom_range(0, 4));
        2: e = 8'($urandom_range(250, 255));
        default: e = 8'($urandom_range(100, 150));
      endcase
      hold = $urandom_range(0, 3);
      send(1'($urandom_range(0, 1)), e, m, ($urandom_range(0, 7) == 0), hold);
    end

    repeat (3) @(posedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
